// File: rtl/mem_backend_if.sv
// Request/response bundle between cache_fsm (master) and mem_backend (slave).
// Handshake: the slave samples req_* only in idle, when req_valid=1 and the request is new; rsp_ready pulses for one cycle per transaction and rsp_data is valid in that cycle.
interface mem_backend_if;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic         req_rw;
    logic         req_valid;
    logic [127:0] rsp_data;
    logic         rsp_ready;

    modport master (output req_addr, req_data, req_rw, req_valid, input rsp_data, rsp_ready);
    modport slave  (input req_addr, req_data, req_rw, req_valid, output rsp_data, rsp_ready);
endinterface

// File: rtl/mem_backend.sv
// Line-granular main-memory model behind cache_fsm with fixed read/write latency.
// Optional MEM_LFSR_LAT_EN adds 0..3 cycles of LFSR-driven latency jitter.
module mem_backend #(
    parameter int DEPTH    = 64,
    parameter int RD_LAT   = 2,
    parameter int WR_LAT   = 5,
    parameter int ADDR_LSB = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_backend_if.slave      mem,
    output logic              busy,
    output logic [1:0]        o_state
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [7:0] RD_BASE = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_BASE = 8'(WR_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [127:0]       r_data;
    logic               r_rw;
    logic [7:0]         r_lat_cnt;
    logic               r_armed;
    logic [31:0]        r_last_addr;
    logic               r_last_rw;
    logic [DEPTH-1:0]   r_valid;
    logic [127:0]       r_rsp_data;
    logic               r_rsp_ready;
    logic               r_busy;
    logic [127:0]       r_mem [DEPTH];

    logic [IW-1:0]      w_idx;
    logic               w_accept_ok;
    logic               w_do_access;
    logic [7:0]         w_jitter;
    logic [7:0]         w_lat_load;
    logic [127:0]       w_fill;

`ifdef MEM_LFSR_LAT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 8'hA5;
        else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_jitter = {6'd0, r_lfsr[1:0]};
`else
    assign w_jitter = 8'd0;
`endif

    assign w_idx       = r_addr[ADDR_LSB +: IW];
    // A held valid after a response must not replay the same request.
    assign w_accept_ok = r_armed || (mem.req_addr != r_last_addr) || (mem.req_rw != r_last_rw);
    assign w_do_access = (r_state == S_BUSY) && (r_lat_cnt == 8'd0);
    assign w_lat_load  = (mem.req_rw ? WR_BASE : RD_BASE) + w_jitter;
    assign w_fill      = {4{r_addr[31:ADDR_LSB], {ADDR_LSB{1'b0}}}};

    always_ff @(posedge clk) begin
        if (w_do_access && r_rw) r_mem[w_idx] <= r_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_rw        <= 1'b0;
            r_lat_cnt   <= '0;
            r_armed     <= 1'b1;
            r_last_addr <= '0;
            r_last_rw   <= 1'b0;
            r_valid     <= '0;
            r_rsp_data  <= '0;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!mem.req_valid) begin
                        r_armed <= 1'b1;
                    end else if (w_accept_ok) begin
                        r_addr    <= mem.req_addr;
                        r_data    <= mem.req_data;
                        r_rw      <= mem.req_rw;
                        r_lat_cnt <= w_lat_load;
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_lat_cnt != 8'd0) begin
                        r_lat_cnt <= r_lat_cnt - 8'd1;
                    end else begin
                        if (r_rw) begin
                            r_valid[w_idx] <= 1'b1;
                            r_rsp_data     <= '0;
                        end else begin
                            r_rsp_data <= r_valid[w_idx] ? r_mem[w_idx] : w_fill;
                        end
                        r_rsp_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_last_addr <= r_addr;
                    r_last_rw   <= r_rw;
                    r_armed     <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.rsp_data  = r_rsp_data;
    assign mem.rsp_ready = r_rsp_ready;
    assign busy          = r_busy;
    assign o_state       = r_state;
endmodule
